inst_loader: RTL and testbench

- Program loader that sits directly upstream of the instruction memory and drives its write port.
- Accepts a byte stream from a host link (UART receiver or testbench) using a valid/ready handshake.
- Stream format: 4-byte little-endian length header, then payload bytes.
- Assembles payload bytes into little-endian words, issues word writes to instruction memory, finishes any trailing bytes with half/byte writes, and holds the CPU in reset until the image is complete.

---
 rtl/inst_loader_if.sv | 22 ++
 rtl/inst_loader.sv | 181 ++++++++++++++++++
 tb/tb_inst_loader.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// master: host/bench side (drives the byte stream, observes the memory port).
// slave:  loader side (consumes the byte stream, drives the memory port).
interface inst_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [3:0]  mem_write_width;
    logic [31:0] mem_write_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_write_enable, mem_write_width, mem_write_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_write_enable, mem_write_width, mem_write_data
    );
endinterface

// File: rtl/inst_loader.sv
// Program loader: takes a length-prefixed byte stream, packs it into
// little-endian words for the instruction memory, finishes a ragged tail
// with half/byte writes and keeps the core in reset until the image is in.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | after reset, waiting for start
// S_LEN       | collecting the 4-byte little-endian length header
// S_DATA      | collecting payload, one word write per 4 bytes
// S_TAIL_HALF | half write of bytes 0..1 of a 3-byte tail is on the port
// S_TAIL_BYTE | final write on the port (or nothing for a 4-byte end)
// S_DONE      | image complete, core released
// S_ERR       | length larger than memory, waiting for start
module inst_loader #(
    parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH_IN_BYTE = 16384
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    inst_loader_if.slave bus,
    output logic         busy,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_TAIL_HALF,
        S_TAIL_BYTE,
        S_DONE,
        S_ERR
    } state_t;

    // Largest payload that still fits between BASE_ADDR and the end of memory.
    localparam logic [31:0] LEN_LIMIT = 32'(MEM_DEPTH_IN_BYTE) - BASE_ADDR;

    state_t      state_q;
    logic [31:0] len_q;
    logic [31:0] cnt_q;
    logic [23:0] buf_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  width_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic [31:0] cnt_d;
    logic [31:0] len_d;
    logic [31:0] word_addr;

    assign accept    = bus.in_valid && bus.in_ready;
    assign cnt_d     = cnt_q + 32'd1;
    // Full header value as it stands when the 4th header byte arrives.
    assign len_d     = {bus.in_data, len_q[23:0]};
    // Counter is still pointing into the word being written, so rounding it
    // down gives the word offset for the word write and for every tail write.
    assign word_addr = BASE_ADDR + {cnt_q[31:2], 2'b00};

    // Status and handshake are pure decodes of the state register.
    assign bus.in_ready = (state_q == S_LEN) || (state_q == S_DATA);
    assign busy         = (state_q == S_LEN) || (state_q == S_DATA) ||
                          (state_q == S_TAIL_HALF) || (state_q == S_TAIL_BYTE);
    assign cpu_hold     = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);

    assign bus.mem_write_enable = we_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_write_width  = width_q;
    assign bus.mem_write_data   = wdata_q;

    // Loader FSM with registered write port; write strobe is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q <= S_LEN;
                        len_q   <= '0;
                        cnt_q   <= '0;
                        buf_q   <= '0;
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        case (cnt_q[1:0])
                            2'd0:    len_q[7:0]   <= bus.in_data;
                            2'd1:    len_q[15:8]  <= bus.in_data;
                            2'd2:    len_q[23:16] <= bus.in_data;
                            default: len_q        <= len_d;
                        endcase
                        if (cnt_q[1:0] == 2'd3) begin
                            cnt_q <= '0;
                            if (len_d == 32'd0) begin
                                state_q <= S_DONE;
                            end else if (len_d > LEN_LIMIT) begin
                                state_q <= S_ERR;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        case (cnt_q[1:0])
                            2'd0:    buf_q[7:0]   <= bus.in_data;
                            2'd1:    buf_q[15:8]  <= bus.in_data;
                            2'd2:    buf_q[23:16] <= bus.in_data;
                            default: ;
                        endcase
                        if (cnt_q[1:0] == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= word_addr;
                            width_q <= 4'd4;
                            wdata_q <= {bus.in_data, buf_q};
                        end
                        if (cnt_d == len_q) begin
                            case (len_q[1:0])
                                2'd0: state_q <= S_TAIL_BYTE;
                                2'd1: begin
                                    we_q    <= 1'b1;
                                    addr_q  <= word_addr;
                                    width_q <= 4'd1;
                                    wdata_q <= {24'd0, bus.in_data};
                                    state_q <= S_TAIL_BYTE;
                                end
                                2'd2: begin
                                    we_q    <= 1'b1;
                                    addr_q  <= word_addr;
                                    width_q <= 4'd2;
                                    wdata_q <= {16'd0, bus.in_data, buf_q[7:0]};
                                    state_q <= S_TAIL_BYTE;
                                end
                                default: begin
                                    we_q    <= 1'b1;
                                    addr_q  <= word_addr;
                                    width_q <= 4'd2;
                                    wdata_q <= {16'd0, buf_q[15:0]};
                                    state_q <= S_TAIL_HALF;
                                end
                            endcase
                        end
                    end
                end

                S_TAIL_HALF: begin
                    // Byte 2 was captured into the buffer with the last accept.
                    we_q    <= 1'b1;
                    addr_q  <= word_addr + 32'd2;
                    width_q <= 4'd1;
                    wdata_q <= {24'd0, buf_q[23:16]};
                    state_q <= S_TAIL_BYTE;
                end

                S_TAIL_BYTE: state_q <= S_DONE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: one instance with default parameters and
// one with BASE_ADDR = 0x100, sharing clock and reset.
module tb_inst_loader;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   sel = 1'b0;
    logic valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic start = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int stall_cycles = 0;

    logic busy0, hold0, done0, err0;
    logic busy1, hold1, done1, err1;
    logic start0, start1;

    inst_loader_if if0 ();
    inst_loader_if if1 ();

    assign if0.in_valid = valid && (sel == 1'b0);
    assign if0.in_data  = data;
    assign if1.in_valid = valid && (sel == 1'b1);
    assign if1.in_data  = data;
    assign start0 = start && (sel == 1'b0);
    assign start1 = start && (sel == 1'b1);

    inst_loader dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(if0.slave),
        .busy(busy0), .cpu_hold(hold0), .done(done0), .error(err0)
    );

    inst_loader #(.BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(if1.slave),
        .busy(busy1), .cpu_hold(hold1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    wire        rdy    = sel ? if1.in_ready : if0.in_ready;
    wire        m_we   = sel ? if1.mem_write_enable : if0.mem_write_enable;
    wire [31:0] m_addr = sel ? if1.mem_addr : if0.mem_addr;
    wire [3:0]  m_w    = sel ? if1.mem_write_width : if0.mem_write_width;
    wire [31:0] m_d    = sel ? if1.mem_write_data : if0.mem_write_data;
    wire        m_busy = sel ? busy1 : busy0;
    wire        m_hold = sel ? hold1 : hold0;
    wire        m_done = sel ? done1 : done0;
    wire        m_err  = sel ? err1 : err0;

    wr_t wq0[$];
    wr_t wq1[$];

    // Every cycle with the strobe high is logged as one write.
    always @(negedge clk) begin
        if (if0.mem_write_enable) wq0.push_back({if0.mem_addr, if0.mem_write_width, if0.mem_write_data});
        if (if1.mem_write_enable) wq1.push_back({if1.mem_addr, if1.mem_write_width, if1.mem_write_data});
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        valid = 1'b1;
        data  = b;
        while (rdy !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout in_ready=%b want 1", rdy);
        end
        stall_cycles += t;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_queues();
        wq0.delete();
        wq1.delete();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rdy, m_we, m_busy, m_hold, m_done, m_err} !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_flags got rdy/we/busy/hold/done/err=%b want 000100",
                     {rdy, m_we, m_busy, m_hold, m_done, m_err});
        end
        n_checks++;
        if ({m_addr, m_w, m_d} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_port got addr=%h w=%h d=%h want 0", m_addr, m_w, m_d);
        end
        n_checks++;
        if ({if1.in_ready, hold1, done1, err1} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_dut1 got %b want 0100", {if1.in_ready, hold1, done1, err1});
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_queues();
    endtask

    task automatic load_prog_a();
        logic [7:0] s[12];
        s = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h10};
        do_start();
        for (int i = 0; i < 12; i++) push_byte(s[i]);
    endtask

    task automatic test_back_to_back();
        wr_t exp_w[2];
        exp_w = '{{32'h0, 4'd4, 32'h0000_0013}, {32'h4, 4'd4, 32'h1000_02B7}};
        sel = 1'b0;
        clear_queues();
        stall_cycles = 0;
        load_prog_a();
        n_checks++;
        if (stall_cycles !== 0) begin
            n_fail++;
            $display("FAIL b2b_bubble got %0d stall cycles want 0", stall_cycles);
        end
        n_checks++;
        if ({m_we, m_addr, m_w, m_d, m_done, rdy} !== {1'b1, 32'h4, 4'd4, 32'h1000_02B7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_last_write got we=%b addr=%h w=%h d=%h done=%b rdy=%b",
                     m_we, m_addr, m_w, m_d, m_done, rdy);
        end
        @(negedge clk);
        n_checks++;
        if ({m_done, m_hold, m_we, m_busy, m_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h4}) begin
            n_fail++;
            $display("FAIL b2b_done got done=%b hold=%b we=%b busy=%b addr=%h want 1 0 0 0 4",
                     m_done, m_hold, m_we, m_busy, m_addr);
        end
        @(negedge clk);
        n_checks++;
        if (wq0.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d writes want 2", wq0.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (wq0[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL b2b_wr%0d got %h want %h", i, wq0[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_tail3_base();
        logic [7:0] s[11];
        wr_t exp_w[3];
        s = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        exp_w = '{{32'h100, 4'd4, 32'h4433_2211}, {32'h104, 4'd2, 32'h0000_6655},
                  {32'h106, 4'd1, 32'h0000_0077}};
        sel = 1'b1;
        clear_queues();
        do_start();
        for (int i = 0; i < 11; i++) push_byte(s[i]);
        n_checks++;
        if ({m_we, m_addr, m_w, m_d, m_busy} !== {1'b1, 32'h104, 4'd2, 32'h6655, 1'b1}) begin
            n_fail++;
            $display("FAIL tail3_half got we=%b addr=%h w=%h d=%h busy=%b", m_we, m_addr, m_w, m_d, m_busy);
        end
        @(negedge clk);
        n_checks++;
        if ({m_we, m_addr, m_w, m_d, m_done} !== {1'b1, 32'h106, 4'd1, 32'h77, 1'b0}) begin
            n_fail++;
            $display("FAIL tail3_byte got we=%b addr=%h w=%h d=%h done=%b", m_we, m_addr, m_w, m_d, m_done);
        end
        @(negedge clk);
        n_checks++;
        if ({m_done, m_hold, m_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL tail3_done got done/hold/we=%b want 100", {m_done, m_hold, m_we});
        end
        @(negedge clk);
        n_checks++;
        if (wq1.size() !== 3) begin
            n_fail++;
            $display("FAIL tail3_count got %0d writes want 3", wq1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wq1[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL tail3_wr%0d got %h want %h", i, wq1[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_tail12();
        logic [7:0] s1[9];
        logic [7:0] s2[6];
        wr_t exp_w[3];
        s1 = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        s2 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12};
        exp_w = '{{32'h0, 4'd4, 32'hDDCC_BBAA}, {32'h4, 4'd1, 32'h0000_00EE},
                  {32'h0, 4'd2, 32'h0000_1234}};
        sel = 1'b0;
        clear_queues();
        do_start();
        n_checks++;
        if ({m_hold, m_done, rdy} !== 3'b101) begin
            n_fail++;
            $display("FAIL restart_hold got hold/done/rdy=%b want 101", {m_hold, m_done, rdy});
        end
        for (int i = 0; i < 9; i++) push_byte(s1[i]);
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tail1_done got %b want 1", m_done);
        end
        do_start();
        for (int i = 0; i < 6; i++) push_byte(s2[i]);
        repeat (3) @(negedge clk);
        n_checks++;
        if (wq0.size() !== 3) begin
            n_fail++;
            $display("FAIL tail12_count got %0d writes want 3", wq0.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wq0[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL tail12_wr%0d got %h want %h", i, wq0[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        sel = 1'b0;
        clear_queues();
        do_start();
        for (int i = 0; i < 4; i++) push_byte(8'h00);
        n_checks++;
        if ({m_done, m_hold, m_err, rdy, m_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL len0_done got done/hold/err/rdy/we=%b want 10000",
                     {m_done, m_hold, m_err, rdy, m_we});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (wq0.size() !== 0) begin
            n_fail++;
            $display("FAIL len0_writes got %0d want 0", wq0.size());
        end
    endtask

    task automatic test_len_error();
        logic [7:0] h[4];
        sel = 1'b0;
        clear_queues();
        h = '{8'h01, 8'h40, 8'h00, 8'h00};
        do_start();
        for (int i = 0; i < 4; i++) push_byte(h[i]);
        // A byte offered while in ERR must not move anything.
        valid = 1'b1;
        data  = 8'h5A;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        n_checks++;
        if ({m_err, rdy, m_hold, m_done, m_busy} !== 5'b10100) begin
            n_fail++;
            $display("FAIL err_flags got err/rdy/hold/done/busy=%b want 10100",
                     {m_err, rdy, m_hold, m_done, m_busy});
        end
        n_checks++;
        if (wq0.size() !== 0) begin
            n_fail++;
            $display("FAIL err_writes got %0d want 0", wq0.size());
        end
        do_start();
        n_checks++;
        if ({rdy, m_err, m_busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL err_restart got rdy/err/busy=%b want 101", {rdy, m_err, m_busy});
        end
        for (int i = 0; i < 4; i++) push_byte(8'h00);
        n_checks++;
        if (m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL err_recover_done got %b want 1", m_done);
        end
        // Offset base: limit is 0x4000 - 0x100 = 0x3F00.
        sel = 1'b1;
        h = '{8'h01, 8'h3F, 8'h00, 8'h00};
        do_start();
        for (int i = 0; i < 4; i++) push_byte(h[i]);
        n_checks++;
        if (m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL base_over got err=%b want 1", m_err);
        end
        h = '{8'h00, 8'h3F, 8'h00, 8'h00};
        do_start();
        for (int i = 0; i < 4; i++) push_byte(h[i]);
        n_checks++;
        if ({m_err, rdy, m_busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL base_limit got err/rdy/busy=%b want 011", {m_err, rdy, m_busy});
        end
    endtask

    task automatic test_reset_mid();
        wr_t exp_w[2];
        logic [7:0] h[4];
        exp_w = '{{32'h0, 4'd4, 32'h0000_0013}, {32'h4, 4'd4, 32'h1000_02B7}};
        h = '{8'h08, 8'h00, 8'h00, 8'h00};
        sel = 1'b0;
        clear_queues();
        do_start();
        for (int i = 0; i < 4; i++) push_byte(h[i]);
        push_byte(8'h13);
        push_byte(8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rdy, m_we, m_busy, m_hold, m_done, m_err, m_addr, m_w, m_d} !== {6'b000100, 68'd0}) begin
            n_fail++;
            $display("FAIL midrst_outputs got flags=%b addr=%h w=%h d=%h",
                     {rdy, m_we, m_busy, m_hold, m_done, m_err}, m_addr, m_w, m_d);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wq0.size() !== 0) begin
            n_fail++;
            $display("FAIL midrst_writes got %0d want 0", wq0.size());
        end
        load_prog_a();
        repeat (3) @(negedge clk);
        n_checks++;
        if (wq0.size() !== 2) begin
            n_fail++;
            $display("FAIL midrst_reload_count got %0d writes want 2", wq0.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (wq0[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL midrst_wr%0d got %h want %h", i, wq0[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_random_valid();
        logic [7:0] s[12];
        wr_t exp_w[2];
        int t;
        s = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h10};
        exp_w = '{{32'h0, 4'd4, 32'h0000_0013}, {32'h4, 4'd4, 32'h1000_02B7}};
        sel = 1'b0;
        clear_queues();
        do_start();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin
                start = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            start = 1'b0;
            push_byte(s[i]);
            if (i == 6) begin
                n_checks++;
                if ({m_hold, m_busy, m_done} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL rnd_midload got hold/busy/done=%b want 110", {m_hold, m_busy, m_done});
                end
            end
        end
        t = 0;
        while (m_done !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_done_timeout got done=%b want 1", m_done);
        end
        @(negedge clk);
        n_checks++;
        if (wq0.size() !== 2) begin
            n_fail++;
            $display("FAIL rnd_count got %0d writes want 2", wq0.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (wq0[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL rnd_wr%0d got %h want %h", i, wq0[i], exp_w[i]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_tail3_base();
        test_tail12();
        test_len_zero();
        test_len_error();
        test_reset_mid();
        test_random_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
